// File: rtl/user_ip_ctrl.sv
// APB4 fan-out to NUM_IP user IP slots with a per-access watchdog, local control
// registers in window 0xF, and a guarded single-owner GPIO pad mux.
module user_ip_ctrl #(
  parameter int NUM_IP    = 4,
  parameter int GPIO_W    = 16,
  parameter int TIMEOUT   = 255,
  parameter int GUARD_RST = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     s_psel,
  input  logic                     s_penable,
  input  logic                     s_pwrite,
  input  logic [11:0]              s_paddr,
  input  logic [31:0]              s_pwdata,
  input  logic [3:0]               s_pstrb,
  output logic [31:0]              s_prdata,
  output logic                     s_pready,
  output logic                     s_pslverr,
  output logic [NUM_IP-1:0]        m_psel,
  output logic                     m_penable,
  output logic                     m_pwrite,
  output logic [7:0]               m_paddr,
  output logic [31:0]              m_pwdata,
  output logic [3:0]               m_pstrb,
  input  logic [NUM_IP*32-1:0]     m_prdata,
  input  logic [NUM_IP-1:0]        m_pready,
  input  logic [NUM_IP-1:0]        m_pslverr,
  input  logic [NUM_IP*GPIO_W-1:0] ip_gpio_out,
  input  logic [NUM_IP*GPIO_W-1:0] ip_gpio_oen,
  output logic [NUM_IP*GPIO_W-1:0] ip_gpio_in,
  output logic [GPIO_W-1:0]        pad_gpio_out,
  output logic [GPIO_W-1:0]        pad_gpio_oen,
  input  logic [GPIO_W-1:0]        pad_gpio_in
);

  localparam logic [3:0] CTRL_WIN   = 4'hF;
  localparam logic [7:0] OFF_SEL    = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_GUARD  = 8'h08;
  localparam logic [7:0] OFF_EN     = 8'h0C;

  typedef enum logic {
    ST_OWN   = 1'b0,
    ST_DRAIN = 1'b1
  } gpio_state_e;

  gpio_state_e       state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [2:0]        owner_q, owner_d;
  logic [2:0]        pending_q, pending_d;
  logic [7:0]        guard_q, guard_d;
  logic [NUM_IP-1:0] en_q, en_d;
  logic              to_flag_q, to_flag_d;
  logic [2:0]        to_slot_q, to_slot_d;
  logic [15:0]       wd_q, wd_d;

  logic [3:0]  win;
  logic [7:0]  off;
  logic        is_ctrl;
  logic        in_range;
  logic        slot_en;
  logic        fwd;
  logic [31:0] slot_rdata;
  logic        slot_ready;
  logic        slot_err;
  logic        timeout_hit;
  logic        ctrl_wr;
  logic        sel_wr;
  logic [2:0]  sel_val;
  logic [31:0] ctrl_rdata;

  assign win     = s_paddr[11:8];
  assign off     = s_paddr[7:0];
  assign is_ctrl = (win == CTRL_WIN);

  // Decode the addressed slot and pick up its completion signals.
  always_comb begin
    in_range   = 1'b0;
    slot_en    = 1'b0;
    slot_rdata = 32'h0;
    slot_ready = 1'b0;
    slot_err   = 1'b0;
    for (int i = 0; i < NUM_IP; i++) begin
      if (win == 4'(i)) begin
        in_range   = 1'b1;
        slot_en    = en_q[i];
        slot_rdata = m_prdata[i*32 +: 32];
        slot_ready = m_pready[i];
        slot_err   = m_pslverr[i];
      end
    end
  end

  assign fwd = in_range & slot_en;

  generate
    for (genvar gi = 0; gi < NUM_IP; gi++) begin : g_psel
      assign m_psel[gi] = s_psel & fwd & (win == 4'(gi));
    end
  endgenerate

  assign m_penable = s_penable;
  assign m_pwrite  = s_pwrite;
  assign m_paddr   = off;
  assign m_pwdata  = s_pwdata;
  assign m_pstrb   = s_pstrb;

  // A slot completing on the very cycle the watchdog expires keeps its own response.
  assign timeout_hit = s_psel & s_penable & fwd & ~slot_ready & (wd_q >= 16'(TIMEOUT));

  assign ctrl_wr = s_psel & s_penable & s_pwrite & is_ctrl;
  assign sel_wr  = ctrl_wr & (off == OFF_SEL) & (s_pwdata < 32'(NUM_IP));
  assign sel_val = s_pwdata[2:0];

  always_comb begin
    ctrl_rdata = 32'h0;
    case (off)
      OFF_SEL:    ctrl_rdata = {29'h0, owner_q};
      OFF_STATUS: ctrl_rdata = {25'h0, to_slot_q, 2'b00, to_flag_q, state_q == ST_DRAIN};
      OFF_GUARD:  ctrl_rdata = {24'h0, guard_q};
      OFF_EN:     ctrl_rdata = {{(32-NUM_IP){1'b0}}, en_q};
      default:    ctrl_rdata = 32'h0;
    endcase
  end

  always_comb begin
    s_prdata  = 32'h0;
    s_pready  = 1'b0;
    s_pslverr = 1'b0;
    if (s_psel) begin
      if (is_ctrl) begin
        s_pready = 1'b1;
        s_prdata = ctrl_rdata;
      end else if (!fwd) begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
      end else if (timeout_hit) begin
        s_pready  = 1'b1;
        s_pslverr = 1'b1;
      end else begin
        s_prdata  = slot_rdata;
        s_pready  = slot_ready;
        s_pslverr = slot_err;
      end
    end
  end

  always_comb begin
    wd_d = wd_q;
    if (!s_psel || s_pready) begin
      wd_d = 16'h0;
    end else if (s_penable) begin
      wd_d = wd_q + 16'd1;
    end
  end

  always_comb begin
    guard_d   = guard_q;
    en_d      = en_q;
    to_flag_d = to_flag_q;
    to_slot_d = to_slot_q;
    if (ctrl_wr) begin
      case (off)
        OFF_GUARD:  guard_d = s_pwdata[7:0];
        OFF_EN:     en_d    = s_pwdata[NUM_IP-1:0];
        OFF_STATUS: if (s_pwdata[1]) to_flag_d = 1'b0;
        default:    ;
      endcase
    end
    if (timeout_hit) begin
      to_flag_d = 1'b1;
      to_slot_d = win[2:0];
    end
  end

  // Ownership switch: any accepted SEL write during DRAIN restarts the guard interval.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    pending_d = pending_q;
    case (state_q)
      ST_OWN: begin
        if (sel_wr && (sel_val != owner_q)) begin
          pending_d = sel_val;
          cnt_d     = 8'h0;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (sel_wr) begin
          pending_d = sel_val;
          cnt_d     = 8'h0;
        end else if (cnt_q >= guard_q) begin
          owner_d = pending_q;
          cnt_d   = 8'h0;
          state_d = ST_OWN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_DRAIN;
    endcase
  end

  always_comb begin
    pad_gpio_out = '0;
    pad_gpio_oen = '1;
    ip_gpio_in   = '0;
    if (state_q == ST_OWN) begin
      for (int i = 0; i < NUM_IP; i++) begin
        if (owner_q == 3'(i)) begin
          pad_gpio_out                   = ip_gpio_out[i*GPIO_W +: GPIO_W];
          pad_gpio_oen                   = ip_gpio_oen[i*GPIO_W +: GPIO_W];
          ip_gpio_in[i*GPIO_W +: GPIO_W] = pad_gpio_in;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_DRAIN;
      cnt_q     <= 8'h0;
      owner_q   <= 3'h0;
      pending_q <= 3'h0;
      guard_q   <= 8'(GUARD_RST);
      en_q      <= '1;
      to_flag_q <= 1'b0;
      to_slot_q <= 3'h0;
      wd_q      <= 16'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      pending_q <= pending_d;
      guard_q   <= guard_d;
      en_q      <= en_d;
      to_flag_q <= to_flag_d;
      to_slot_q <= to_slot_d;
      wd_q      <= wd_d;
    end
  end

endmodule

// File: tb/tb_user_ip_ctrl.sv
// Randomized self-checking bench for user_ip_ctrl: a behavioural model of the
// register file, drain countdown and watchdog is compared against the DUT every cycle.
module tb_user_ip_ctrl;

  localparam int NUM_IP    = 4;
  localparam int GPIO_W    = 16;
  localparam int TIMEOUT   = 255;
  localparam int GUARD_RST = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic s_psel = 1'b0, s_penable = 1'b0, s_pwrite = 1'b0;
  logic [11:0] s_paddr = '0;
  logic [31:0] s_pwdata = '0;
  logic [3:0]  s_pstrb = '0;
  logic [31:0] s_prdata;
  logic        s_pready, s_pslverr;
  logic [NUM_IP-1:0] m_psel;
  logic        m_penable, m_pwrite;
  logic [7:0]  m_paddr;
  logic [31:0] m_pwdata;
  logic [3:0]  m_pstrb;
  logic [NUM_IP*32-1:0] m_prdata;
  logic [NUM_IP-1:0] m_pready, m_pslverr;
  logic [NUM_IP*GPIO_W-1:0] ip_gpio_out, ip_gpio_oen, ip_gpio_in;
  logic [GPIO_W-1:0] pad_gpio_out, pad_gpio_oen;
  logic [GPIO_W-1:0] pad_gpio_in = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  user_ip_ctrl #(.NUM_IP(NUM_IP), .GPIO_W(GPIO_W), .TIMEOUT(TIMEOUT), .GUARD_RST(GUARD_RST)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite), .s_paddr(s_paddr),
    .s_pwdata(s_pwdata), .s_pstrb(s_pstrb), .s_prdata(s_prdata), .s_pready(s_pready),
    .s_pslverr(s_pslverr), .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pstrb(m_pstrb), .m_prdata(m_prdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .ip_gpio_out(ip_gpio_out),
    .ip_gpio_oen(ip_gpio_oen), .ip_gpio_in(ip_gpio_in), .pad_gpio_out(pad_gpio_out),
    .pad_gpio_oen(pad_gpio_oen), .pad_gpio_in(pad_gpio_in)
  );

  // Slot models: slot i answers i + (offset << 8), errors on offset bit 7,
  // and becomes ready after need[i] access-phase cycles.
  int need[NUM_IP];
  int wcnt[NUM_IP];
  logic [GPIO_W-1:0] g_out[NUM_IP];
  logic [GPIO_W-1:0] g_oen[NUM_IP];

  generate
    for (genvar gi = 0; gi < NUM_IP; gi++) begin : g_slot
      assign m_prdata[gi*32 +: 32]        = 32'(gi) + {16'h0, m_paddr, 8'h0};
      assign m_pready[gi]                 = (wcnt[gi] >= need[gi]);
      assign m_pslverr[gi]                = m_paddr[7];
      assign ip_gpio_out[gi*GPIO_W +: GPIO_W] = g_out[gi];
      assign ip_gpio_oen[gi*GPIO_W +: GPIO_W] = g_oen[gi];
    end
  endgenerate

  always @(posedge clk) begin
    for (int i = 0; i < NUM_IP; i++) begin
      if (m_psel[i] && m_penable && !m_pready[i]) wcnt[i] <= wcnt[i] + 1;
      else                                        wcnt[i] <= 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  logic [NUM_IP-1:0] md_en;
  logic [7:0]        md_guard;
  int                md_owner, md_pending, md_drain, md_k, md_toslot;
  logic              md_flag;

  function automatic void model_reset();
    md_en      = '1;
    md_guard   = 8'(GUARD_RST);
    md_owner   = 0;
    md_pending = 0;
    md_drain   = GUARD_RST + 1;
    md_k       = 0;
    md_flag    = 1'b0;
    md_toslot  = 0;
  endfunction

  function automatic logic [31:0] ctrl_read(input logic [7:0] o);
    case (o)
      8'h00:   return 32'(md_owner);
      8'h04:   return 32'(md_toslot * 16 + (md_flag ? 2 : 0) + (md_drain > 0 ? 1 : 0));
      8'h08:   return 32'(md_guard);
      8'h0C:   return 32'(md_en);
      default: return 32'h0;
    endcase
  endfunction

  always @(negedge clk) begin : cmp
    logic [3:0]  w;
    logic [7:0]  o;
    logic        ctrl, fwd, e_ready, e_err, e_to, sel_ok;
    logic [31:0] e_rdata;
    logic [NUM_IP-1:0] e_msel;
    logic [GPIO_W-1:0] e_out, e_oen;
    logic [NUM_IP*GPIO_W-1:0] e_in;
    int sel_v;
    if (rst) model_reset();
    e_out = '0; e_oen = '1; e_in = '0;
    if (md_drain == 0) begin
      e_out = g_out[md_owner];
      e_oen = g_oen[md_owner];
      e_in[md_owner*GPIO_W +: GPIO_W] = pad_gpio_in;
    end
    chk("pad_gpio_out", pad_gpio_out, e_out);
    chk("pad_gpio_oen", pad_gpio_oen, e_oen);
    chk("ip_gpio_in", ip_gpio_in, e_in);
    w = s_paddr[11:8];
    o = s_paddr[7:0];
    ctrl = (w == 4'hF);
    fwd = (int'(w) < NUM_IP) ? md_en[int'(w)] : 1'b0;
    e_msel = '0;
    if (s_psel && fwd) e_msel[int'(w)] = 1'b1;
    chk("m_psel", m_psel, e_msel);
    e_ready = 1'b0; e_err = 1'b0; e_to = 1'b0; e_rdata = '0;
    if (s_psel) begin
      chk("m_paddr", m_paddr, o);
      chk("m_pwdata", m_pwdata, s_pwdata);
      chk("m_pstrb", m_pstrb, s_pstrb);
      chk("m_ctl", {m_penable, m_pwrite}, {s_penable, s_pwrite});
    end
    if (s_psel && s_penable) begin
      if (ctrl) begin
        e_ready = 1'b1; e_rdata = ctrl_read(o);
      end else if (!fwd) begin
        e_ready = 1'b1; e_err = 1'b1;
      end else if (md_k >= need[int'(w)]) begin
        e_ready = 1'b1; e_err = o[7]; e_rdata = 32'(w) + {16'h0, o, 8'h0};
      end else if (md_k >= TIMEOUT) begin
        e_ready = 1'b1; e_err = 1'b1; e_to = 1'b1;
      end
      chk("s_pready", s_pready, e_ready);
      if (e_ready) begin
        chk("s_pslverr", s_pslverr, e_err);
        if (!s_pwrite) chk("s_prdata", s_prdata, e_rdata);
      end
    end
    if (!rst) begin
      sel_ok = 1'b0; sel_v = 0;
      if (s_psel && s_penable) begin
        md_k = e_ready ? 0 : md_k + 1;
        if (e_to) begin md_flag = 1'b1; md_toslot = int'(w); end
        if (ctrl && s_pwrite) begin
          case (o)
            8'h00: if (s_pwdata < NUM_IP) begin sel_ok = 1'b1; sel_v = int'(s_pwdata); end
            8'h04: if (s_pwdata[1]) md_flag = 1'b0;
            8'h08: md_guard = s_pwdata[7:0];
            8'h0C: md_en = s_pwdata[NUM_IP-1:0];
            default: ;
          endcase
        end
      end else begin
        md_k = 0;
      end
      if (md_drain > 0) begin
        if (sel_ok) begin
          md_pending = sel_v; md_drain = int'(md_guard) + 1;
        end else begin
          md_drain--;
          if (md_drain == 0) md_owner = md_pending;
        end
      end else if (sel_ok && sel_v != md_owner) begin
        md_pending = sel_v; md_drain = int'(md_guard) + 1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      pad_gpio_in = GPIO_W'($urandom);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int waits);
    logic done;
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = wr; s_paddr = addr;
    s_pwdata = wdata; s_pstrb = 4'($urandom);
    @(posedge clk); #1;
    s_penable = 1'b1;
    done = 1'b0; waits = 0; rdata = '0; err = 1'b0;
    while (!done && waits < 1000) begin
      @(negedge clk);
      if (s_pready) begin rdata = s_prdata; err = s_pslverr; done = 1'b1; end
      else waits++;
      @(posedge clk); #1;
    end
    chk("apb_completed", done, 1'b1);
    s_psel = 1'b0; s_penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain_check(input string nm, input int exp_cycles, input int slot);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pad_gpio_oen === {GPIO_W{1'b1}}) cnt++;
      else break;
    end
    chk({nm, "_cycles"}, cnt, exp_cycles);
    chk({nm, "_owner_oen"}, pad_gpio_oen, g_oen[slot]);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          wt, cnt;
  logic [11:0] addr;
  logic [31:0] v;

  initial begin
    for (int i = 0; i < NUM_IP; i++) begin
      need[i]  = 0;
      g_out[i] = GPIO_W'($urandom);
      g_oen[i] = GPIO_W'($urandom) & 16'h7FFF;
    end
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    drain_check("reset_drain", GUARD_RST + 1, 0);
    apb(0, 12'hF00, 0, rd, er, wt); chk("rst_sel", rd, 32'h0);
    apb(0, 12'hF0C, 0, rd, er, wt); chk("rst_en", rd, 32'hF);
    apb(0, 12'hF08, 0, rd, er, wt); chk("rst_guard", rd, 32'h4);
    apb(0, 12'hF04, 0, rd, er, wt); chk("rst_status", rd, 32'h0);
    apb(0, 12'hF40, 0, rd, er, wt); chk("unmapped_rd", rd, 32'h0);

    for (int i = 0; i < NUM_IP; i++) begin
      addr = 12'(i * 256);
      apb(0, addr, 0, rd, er, wt);
      $display("read slot %0d: rdata %0h err %0d waits %0d", i, rd, er, wt);
      chk("slot_id_rdata", rd, 32'(i));
      chk("slot_id_err", er, 1'b0);
      chk("slot_id_waits", wt, 0);
    end

    need[2] = 1000;
    apb(0, 12'h204, 0, rd, er, wt);
    chk("timeout_waits", wt, 255); chk("timeout_err", er, 1'b1); chk("timeout_rdata", rd, 32'h0);
    apb(0, 12'hF04, 0, rd, er, wt); chk("status_after_to", rd, 32'h22);
    apb(1, 12'hF04, 32'h2, rd, er, wt);
    apb(0, 12'hF04, 0, rd, er, wt); chk("status_w1c", rd, 32'h20);
    need[2] = 255;
    apb(0, 12'h204, 0, rd, er, wt);
    chk("tie_waits", wt, 255); chk("tie_err", er, 1'b0); chk("tie_rdata", rd, 32'h402);
    apb(0, 12'hF04, 0, rd, er, wt); chk("tie_status", rd, 32'h20);
    need[2] = 0;

    apb(1, 12'hF00, 32'h3, rd, er, wt);
    drain_check("sel3", 5, 3);
    apb(0, 12'hF00, 0, rd, er, wt); chk("sel3_read", rd, 32'h3);
    apb(1, 12'hF00, 32'h1, rd, er, wt);
    apb(1, 12'hF00, 32'h2, rd, er, wt);
    drain_check("sel_restart", 5, 2);
    apb(0, 12'hF00, 0, rd, er, wt); chk("sel2_read", rd, 32'h2);
    apb(1, 12'hF00, 32'h9, rd, er, wt);
    apb(0, 12'hF04, 0, rd, er, wt); chk("sel_ignored_busy", rd[0], 1'b0);

    apb(1, 12'hF0C, 32'hB, rd, er, wt);
    apb(0, 12'h204, 0, rd, er, wt);
    chk("dis_err", er, 1'b1); chk("dis_rdata", rd, 32'h0); chk("dis_waits", wt, 0);
    apb(0, 12'h500, 0, rd, er, wt);
    chk("oor_err", er, 1'b1); chk("oor_rdata", rd, 32'h0); chk("oor_waits", wt, 0);
    apb(1, 12'hF0C, 32'hF, rd, er, wt);

    apb(1, 12'hF08, 32'h0, rd, er, wt);
    apb(1, 12'hF00, 32'h0, rd, er, wt);
    drain_check("guard0", 1, 0);

    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < NUM_IP; i++) need[i] = $urandom_range(0, 3);
      if ($urandom_range(0, 99) < 35) begin
        addr = {4'hF, 8'($urandom_range(0, 4) * 4)};
        if ($urandom_range(0, 7) == 0) addr[7:0] = 8'($urandom) & 8'hFC;
        v = $urandom;
        if (addr[7:0] == 8'h00 && $urandom_range(0, 3) != 0) v = $urandom_range(0, 7);
        if (addr[7:0] == 8'h08) v[7:0] = 8'($urandom_range(0, 6));
        if (addr[7:0] == 8'h08 && md_drain != 0) apb(0, addr, v, rd, er, wt);
        else apb(1'($urandom), addr, v, rd, er, wt);
      end else begin
        addr = {4'($urandom_range(0, NUM_IP - 1)), 8'($urandom)};
        if ($urandom_range(0, 4) == 0) addr[11:8] = 4'($urandom_range(0, 15));
        if (int'(addr[11:8]) < NUM_IP && $urandom_range(0, 29) == 0)
          need[int'(addr[11:8])] = ($urandom_range(0, 1) == 0) ? 255 : 1000;
        apb(1'($urandom), addr, $urandom, rd, er, wt);
      end
      $display("txn %0d: addr %03h rdata %08h err %0d waits %0d", t, addr, rd, er, wt);
      idle($urandom_range(0, 2));
    end

    for (int i = 0; i < NUM_IP; i++) need[i] = 0;
    apb(1, 12'hF00, 32'h3, rd, er, wt);
    idle(12);
    apb(1, 12'hF0C, 32'h3, rd, er, wt);
    apb(1, 12'hF08, 32'h7, rd, er, wt);
    need[1] = 1000;
    s_psel = 1'b1; s_penable = 1'b0; s_pwrite = 1'b0; s_paddr = 12'h110;
    @(posedge clk); #1;
    s_penable = 1'b1;
    idle(10);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_async_oen", pad_gpio_oen, 16'hFFFF);
    chk("rst_async_out", pad_gpio_out, 16'h0);
    chk("rst_async_ipin", ip_gpio_in, '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (s_pready) break;
      cnt++;
    end
    chk("rst_wd_restart", cnt, 255);
    chk("rst_wd_err", s_pslverr, 1'b1);
    @(posedge clk); #1;
    s_psel = 1'b0; s_penable = 1'b0;
    need[1] = 0;
    apb(0, 12'hF00, 0, rd, er, wt); chk("rst2_sel", rd, 32'h0);
    apb(0, 12'hF0C, 0, rd, er, wt); chk("rst2_en", rd, 32'hF);
    apb(0, 12'hF08, 0, rd, er, wt); chk("rst2_guard", rd, 32'h4);
    apb(0, 12'hF04, 0, rd, er, wt); chk("rst2_status", rd, 32'h12);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/user_ip_ctrl.md
Name: user_ip_ctrl

Overview:
- Sits between the SoC APB4 bus and NUM_IP user IP slots.
- Decodes each access to one slot's 256-byte window and forwards it, with a per-access timeout watchdog.
- Muxes exactly one slot's GPIO onto the shared pads; a guarded switch sequence tri-states the pads between owners.
- Exposes its own control registers in window 0xF.

Parameters:
NUM_IP, 4, number of user IP slots (1..8)
GPIO_W, 16, pad GPIO width per slot
TIMEOUT, 255, access-phase cycles before a forced error completion (1..65535)
GUARD_RST, 4, reset value of GUARD register (8-bit)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
s_psel/s_penable/s_pwrite  in  1 each  upstream APB4 control
s_paddr  in  12  upstream address: [11:8] window, [7:0] offset
s_pwdata  in  32  upstream write data
s_pstrb  in  4  upstream byte strobes
s_prdata  out  32  upstream read data
s_pready/s_pslverr  out  1 each  upstream completion
m_psel  out  NUM_IP  per-slot select
m_penable/m_pwrite  out  1 each  broadcast
m_paddr  out  8  broadcast offset
m_pwdata  out  32  broadcast
m_pstrb  out  4  broadcast
m_prdata  in  NUM_IP*32  slot read data
m_pready/m_pslverr  in  NUM_IP each  slot completion
ip_gpio_out/ip_gpio_oen  in  NUM_IP*GPIO_W  slot drives; oen active-low
ip_gpio_in  out  NUM_IP*GPIO_W  pad input to slots
pad_gpio_out/pad_gpio_oen  out  GPIO_W  to pads
pad_gpio_in  in  GPIO_W  from pads

Behaviour:
- Control registers, window 0xF, offset [7:0]:
  - 0x00 SEL: [2:0] requested slot. Reads return the current owner.
  - 0x04 STATUS: [0] switch busy; [1] timeout sticky, W1C; [6:4] slot of last timeout.
  - 0x08 GUARD: [7:0] drain cycles.
  - 0x0C EN: [NUM_IP-1:0] slot enable; reset all-ones.
  - Control accesses complete with pready=1 in the access phase, zero wait states.
  - Unmapped offsets read 0; writes to them are ignored.
  - SEL writes with value >= NUM_IP are ignored.
- Forwarding:
  - m_psel[w] = s_psel when window w < NUM_IP and EN[w]=1.
  - m_penable, m_pwrite, m_paddr, m_pwdata and m_pstrb pass through combinationally. No added latency.
  - s_prdata, s_pready and s_pslverr are muxed from the addressed slot.
- Non-forwarded accesses: window >= NUM_IP (not 0xF), or a disabled slot. Completes immediately with pready=1, pslverr=1, prdata=0.
- Watchdog:
  - 16-bit counter increments each cycle that s_psel & s_penable & !s_pready.
  - Clears on completion or when s_psel is low.
  - When the counter reaches TIMEOUT: force s_pready=1 and s_pslverr=1 for one cycle, prdata=0, set STATUS[1], record the slot.
  - A slot pready arriving in the same cycle as the timeout wins: normal completion, no flag.
- GPIO FSM, states OWN and DRAIN:
  - OWN: pads driven by owner slot: pad_gpio_out/oen = ip_gpio_out/oen[owner].
  - DRAIN: pad_gpio_oen all-ones, pad_gpio_out = 0; counts GUARD cycles. At count == GUARD: owner <= pending, go to OWN.
  - GUARD = 0 means DRAIN lasts exactly one cycle.
  - SEL write equal to the owner while in OWN: no transition.
  - SEL write differing from the owner while in OWN: pending <= value, go to DRAIN.
  - SEL write while in DRAIN: pending updated, drain counter restarts.
  - STATUS[0] = (state == DRAIN).
- ip_gpio_in:
  - Owner slot receives pad_gpio_in.
  - Non-owners receive 0.
  - During DRAIN all slots receive 0.
- Reset:
  - State DRAIN, counter 0, pending 0, owner 0, GUARD = GUARD_RST.
  - EN all-ones, STATUS 0, watchdog 0.
  - Pads tri-stated until slot 0 takes ownership GUARD_RST+1 cycles after reset release.
  - Asserting rst_i mid-access or mid-drain returns all of the above asynchronously. Upstream outputs reflect the combinational state.

Test Plan:
- Read 0x000, 0x100, 0x200, 0x300 with slot IDs 0..3 -> prdata 0,1,2,3; pready same cycle; pslverr=0.
- Slot 2 holds pready low; read 0x204 -> completion exactly 255 access cycles later with pslverr=1; STATUS reads 0x22; writing 0x2 to STATUS clears bit1.
- After reset, GUARD=4: pad_gpio_oen=0xFFFF for 5 cycles, then equals slot 0 oen. Write SEL=3 -> 5 drain cycles, then pads follow slot 3; SEL reads 3.
- Write SEL=1, then SEL=2 after 2 drain cycles -> drain restarts, total 2+5 cycles; owner becomes 2; slot 1 never drives.
- Write EN=0xB, read 0x204 -> pready=1, pslverr=1, prdata=0, m_psel never asserted. Access 0x500 behaves identically.
- Assert rst_i during a slot-1 wait state with owner=3 -> watchdog 0, owner 0, state DRAIN, EN=0xF, pads tri-stated.
